// File: rtl/culsans_tohost_pkg.sv
// Shared constants, state types and byte-merge helper for the HTIF tohost/fromhost endpoint.
package culsans_tohost_pkg;

    localparam logic [63:0] TOHOST_OFS   = 64'h0;
    localparam logic [63:0] FROMHOST_OFS = 64'h8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [7:0] DEV_SYS     = 8'h00;
    localparam logic [7:0] DEV_CONSOLE = 8'h01;
    localparam logic [7:0] CMD_PUTCHAR = 8'h01;

    // fromhost acknowledge after a console putchar
    localparam logic [63:0] PUTCHAR_ACK = {DEV_CONSOLE, CMD_PUTCHAR, 47'b0, 1'b1};

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_e;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  strb);
        logic [63:0] merged;
        merged = old_val;
        for (int unsigned i = 0; i < 8; i++) begin
            if (strb[i]) merged[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/culsans_tohost_decode.sv
// Classifies a tohost value as an exit or console-putchar command.
module culsans_tohost_decode
    import culsans_tohost_pkg::*;
(
    input  logic [63:0] value,
    output logic        is_exit,
    output logic        is_putchar,
    output logic [7:0]  ch
);

    always_comb begin
        is_exit    = value[0] && (value[63:56] == DEV_SYS) && (value[55:48] == 8'h00);
        is_putchar = (value[63:56] == DEV_CONSOLE) && (value[55:48] == CMD_PUTCHAR);
        ch         = value[7:0];
    end

endmodule

// File: rtl/culsans_tohost_ctrl.sv
// AXI-Lite HTIF endpoint: tohost/fromhost registers, sticky exit word and console strobe.
module culsans_tohost_ctrl
    import culsans_tohost_pkg::*;
#(
    parameter int unsigned              AddrWidth  = 64,
    parameter int unsigned              DataWidth  = 64,
    parameter logic [AddrWidth-1:0]     BaseAddr   = 64'h8000_1000,
    parameter logic [AddrWidth-1:0]     RegionMask = 64'hFFF
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [1:0]             b_resp_o,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic [31:0]            exit_o,
    output logic                   char_valid_o,
    output logic [7:0]             char_o
);

    wstate_e wstate, wstate_next;
    rstate_e rstate, rstate_next;

    logic [AddrWidth-1:0] aw_addr_q;
    logic [63:0]          w_data_q;
    logic [7:0]           w_strb_q;
    logic [63:0]          tohost, fromhost;

    logic                 aw_hs, w_hs, ar_hs, commit;
    logic [AddrWidth-1:0] wr_addr, wr_ofs, rd_ofs;
    logic [63:0]          wr_data, tohost_merged;
    logic [7:0]           wr_strb;
    logic                 is_exit, is_putchar;
    logic [7:0]           put_ch;

    assign aw_ready_o = rst && (wstate == W_IDLE || wstate == W_HAVE_W);
    assign w_ready_o  = rst && (wstate == W_IDLE || wstate == W_HAVE_AW);
    assign ar_ready_o = rst && (rstate == R_IDLE);
    assign b_valid_o  = (wstate == W_RESP);
    assign r_valid_o  = (rstate == R_RESP);

    assign aw_hs = aw_valid_i && aw_ready_o;
    assign w_hs  = w_valid_i && w_ready_o;
    assign ar_hs = ar_valid_i && ar_ready_o;

    // The half that arrived earlier comes from its holding register.
    assign wr_addr = (wstate == W_HAVE_AW) ? aw_addr_q : aw_addr_i;
    assign wr_data = (wstate == W_HAVE_W)  ? w_data_q  : w_data_i;
    assign wr_strb = (wstate == W_HAVE_W)  ? w_strb_q  : w_strb_i;
    assign wr_ofs  = (wr_addr - BaseAddr) & RegionMask;
    assign rd_ofs  = (ar_addr_i - BaseAddr) & RegionMask;

    assign tohost_merged = merge_bytes(tohost, wr_data, wr_strb);

    culsans_tohost_decode u_decode (
        .value      (tohost_merged),
        .is_exit    (is_exit),
        .is_putchar (is_putchar),
        .ch         (put_ch)
    );

    always_comb begin
        wstate_next = wstate;
        commit      = 1'b0;
        case (wstate)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wstate_next = W_RESP;
                    commit      = 1'b1;
                end else if (aw_hs) begin
                    wstate_next = W_HAVE_AW;
                end else if (w_hs) begin
                    wstate_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: if (w_hs) begin
                wstate_next = W_RESP;
                commit      = 1'b1;
            end
            W_HAVE_W: if (aw_hs) begin
                wstate_next = W_RESP;
                commit      = 1'b1;
            end
            W_RESP: if (b_ready_i) wstate_next = W_IDLE;
            default: wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_next = rstate;
        case (rstate)
            R_IDLE:  if (ar_hs) rstate_next = R_RESP;
            R_RESP:  if (r_ready_i) rstate_next = R_IDLE;
            default: rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            wstate       <= W_IDLE;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            tohost       <= '0;
            fromhost     <= '0;
            b_resp_o     <= RESP_OKAY;
            exit_o       <= '0;
            char_valid_o <= 1'b0;
            char_o       <= '0;
        end else begin
            wstate       <= wstate_next;
            char_valid_o <= 1'b0;
            if (aw_hs) aw_addr_q <= aw_addr_i;
            if (w_hs) begin
                w_data_q <= w_data_i;
                w_strb_q <= w_strb_i;
            end
            if (commit) begin
                if (wr_ofs == AddrWidth'(TOHOST_OFS)) begin
                    b_resp_o <= RESP_OKAY;
                    if (is_exit) begin
                        if (!exit_o[0]) exit_o <= tohost_merged[31:0];
                        tohost <= '0;
                    end else if (is_putchar) begin
                        char_valid_o <= 1'b1;
                        char_o       <= put_ch;
                        tohost       <= '0;
                        fromhost     <= PUTCHAR_ACK;
                    end else begin
                        tohost <= tohost_merged;
                    end
                end else if (wr_ofs == AddrWidth'(FROMHOST_OFS)) begin
                    b_resp_o <= RESP_OKAY;
                    fromhost <= merge_bytes(fromhost, wr_data, wr_strb);
                end else begin
                    b_resp_o <= RESP_SLVERR;
                end
            end
        end
    end

    // Reads sample the registers before any same-edge write commit lands.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            rstate   <= R_IDLE;
            r_data_o <= '0;
            r_resp_o <= RESP_OKAY;
        end else begin
            rstate <= rstate_next;
            if (ar_hs) begin
                if (rd_ofs == AddrWidth'(TOHOST_OFS)) begin
                    r_data_o <= tohost;
                    r_resp_o <= RESP_OKAY;
                end else if (rd_ofs == AddrWidth'(FROMHOST_OFS)) begin
                    r_data_o <= fromhost;
                    r_resp_o <= RESP_OKAY;
                end else begin
                    r_data_o <= '0;
                    r_resp_o <= RESP_SLVERR;
                end
            end
        end
    end

endmodule

// File: tb/tb_culsans_tohost_ctrl.sv
// Directed self-checking bench for culsans_tohost_ctrl with hand-computed expectations.
module tb_culsans_tohost_ctrl;

    localparam logic [63:0] A_TOHOST   = 64'h8000_1000;
    localparam logic [63:0] A_FROMHOST = 64'h8000_1008;
    localparam logic [63:0] A_BAD      = 64'h8000_1010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        aw_valid = 1'b0, aw_ready;
    logic [63:0] aw_addr = '0;
    logic        w_valid = 1'b0, w_ready;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        b_valid, b_ready = 1'b0;
    logic [1:0]  b_resp;
    logic        ar_valid = 1'b0, ar_ready;
    logic [63:0] ar_addr = '0;
    logic        r_valid, r_ready = 1'b0;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [31:0] exit_word;
    logic        char_valid;
    logic [7:0]  char_val;

    int n_checks = 0;
    int n_errors = 0;

    culsans_tohost_ctrl #(
        .AddrWidth  (64),
        .DataWidth  (64),
        .BaseAddr   (64'h8000_1000),
        .RegionMask (64'hFFF)
    ) dut (
        .clk_i        (clk),
        .rst          (rst),
        .aw_valid_i   (aw_valid),
        .aw_ready_o   (aw_ready),
        .aw_addr_i    (aw_addr),
        .w_valid_i    (w_valid),
        .w_ready_o    (w_ready),
        .w_data_i     (w_data),
        .w_strb_i     (w_strb),
        .b_valid_o    (b_valid),
        .b_ready_i    (b_ready),
        .b_resp_o     (b_resp),
        .ar_valid_i   (ar_valid),
        .ar_ready_o   (ar_ready),
        .ar_addr_i    (ar_addr),
        .r_valid_o    (r_valid),
        .r_ready_i    (r_ready),
        .r_data_o     (r_data),
        .r_resp_o     (r_resp),
        .exit_o       (exit_word),
        .char_valid_o (char_valid),
        .char_o       (char_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Leaves the bench #1 after the commit edge; w_first routes through W_HAVE_W.
    task automatic wr(input logic [63:0] addr, input logic [63:0] data,
                      input logic [7:0] strb, input bit w_first);
        @(negedge clk);
        aw_addr = addr;
        w_data  = data;
        w_strb  = strb;
        w_valid = 1'b1;
        if (!w_first) aw_valid = 1'b1;
        @(posedge clk); #1;
        if (w_first) begin
            w_valid = 1'b0;
            check("have_w aw_ready", 64'(aw_ready), 64'd1);
            check("have_w w_ready", 64'(w_ready), 64'd0);
            aw_valid = 1'b1;
            @(posedge clk); #1;
        end
        aw_valid = 1'b0;
        w_valid  = 1'b0;
    endtask

    task automatic bresp(input logic [1:0] exp_resp);
        check("b_valid", 64'(b_valid), 64'd1);
        check("b_resp", 64'(b_resp), 64'(exp_resp));
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0;
        check("b_valid drop", 64'(b_valid), 64'd0);
    endtask

    task automatic rd(input string tag, input logic [63:0] addr,
                      input logic [63:0] exp_data, input logic [1:0] exp_resp);
        @(negedge clk);
        ar_addr  = addr;
        ar_valid = 1'b1;
        @(posedge clk); #1;
        ar_valid = 1'b0;
        check({tag, " r_valid"}, 64'(r_valid), 64'd1);
        check({tag, " r_data"}, r_data, exp_data);
        check({tag, " r_resp"}, 64'(r_resp), 64'(exp_resp));
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst aw_ready", 64'(aw_ready), 64'd0);
        check("rst w_ready", 64'(w_ready), 64'd0);
        check("rst ar_ready", 64'(ar_ready), 64'd0);
        check("rst b_valid", 64'(b_valid), 64'd0);
        check("rst r_valid", 64'(r_valid), 64'd0);
        check("rst exit", 64'(exit_word), 64'd0);
        check("rst char_valid", 64'(char_valid), 64'd0);
        check("rst r_data", r_data, 64'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("idle aw_ready", 64'(aw_ready), 64'd1);
        check("idle ar_ready", 64'(ar_ready), 64'd1);

        // Exit with success, AW and W together
        wr(A_TOHOST, 64'h1, 8'hFF, 1'b0);
        check("exit1 exit", 64'(exit_word), 64'h1);
        bresp(2'b00);
        rd("exit1 tohost", A_TOHOST, 64'h0, 2'b00);

        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        check("rst2 exit", 64'(exit_word), 64'd0);

        // Exit code 42, W ahead of AW; first exit is sticky
        wr(A_TOHOST, 64'h55, 8'hFF, 1'b1);
        check("exit42 exit", 64'(exit_word), 64'h55);
        bresp(2'b00);
        wr(A_TOHOST, 64'h3, 8'hFF, 1'b0);
        check("exit sticky", 64'(exit_word), 64'h55);
        bresp(2'b00);
        rd("exit2 tohost", A_TOHOST, 64'h0, 2'b00);

        // Console putchar
        wr(A_TOHOST, 64'h0101_0000_0000_0041, 8'hFF, 1'b0);
        check("putc strobe", 64'(char_valid), 64'd1);
        check("putc char", 64'(char_val), 64'h41);
        bresp(2'b00);
        check("putc strobe drop", 64'(char_valid), 64'd0);
        rd("putc fromhost", A_FROMHOST, 64'h0101_0000_0000_0001, 2'b00);
        rd("putc tohost", A_TOHOST, 64'h0, 2'b00);

        // Out-of-map offset
        wr(A_BAD, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
        bresp(2'b10);
        check("bad exit", 64'(exit_word), 64'h55);
        rd("bad tohost", A_TOHOST, 64'h0, 2'b00);
        rd("bad fromhost", A_FROMHOST, 64'h0101_0000_0000_0001, 2'b00);
        rd("bad read", A_BAD, 64'h0, 2'b10);

        // B back-pressure with a queued write and a concurrent read
        wr(A_TOHOST, 64'h100, 8'hFF, 1'b0);
        aw_addr  = A_TOHOST;
        w_data   = 64'h200;
        w_strb   = 8'hFF;
        aw_valid = 1'b1;
        w_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp b_valid", 64'(b_valid), 64'd1);
            check("bp aw_ready", 64'(aw_ready), 64'd0);
            check("bp w_ready", 64'(w_ready), 64'd0);
            @(posedge clk); #1;
        end
        rd("bp tohost", A_TOHOST, 64'h100, 2'b00);
        check("bp b_valid held", 64'(b_valid), 64'd1);
        check("bp b_resp held", 64'(b_resp), 64'd0);
        check("bp aw_ready held", 64'(aw_ready), 64'd0);
        b_ready = 1'b1;
        @(posedge clk); #1;
        b_ready = 1'b0;
        check("bp released b_valid", 64'(b_valid), 64'd0);
        check("bp released aw_ready", 64'(aw_ready), 64'd1);
        @(posedge clk); #1;
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        bresp(2'b00);
        rd("bp second", A_TOHOST, 64'h200, 2'b00);

        // Byte strobes
        wr(A_TOHOST, 64'h1122_3344_5566_7788, 8'hF0, 1'b0);
        bresp(2'b00);
        rd("strb tohost", A_TOHOST, 64'h1122_3344_0000_0200, 2'b00);
        wr(A_FROMHOST, 64'hFFFF_FFFF_FFFF_FFFF, 8'h02, 1'b0);
        bresp(2'b00);
        rd("strb fromhost", A_FROMHOST, 64'h0101_0000_0000_FF01, 2'b00);

        // Reset while waiting for W
        @(negedge clk);
        aw_addr  = A_TOHOST;
        aw_valid = 1'b1;
        @(posedge clk); #1;
        aw_valid = 1'b0;
        check("have_aw aw_ready", 64'(aw_ready), 64'd0);
        check("have_aw w_ready", 64'(w_ready), 64'd1);
        rst = 1'b0;
        #1;
        check("midrst w_ready", 64'(w_ready), 64'd0);
        check("midrst exit", 64'(exit_word), 64'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("post aw_ready", 64'(aw_ready), 64'd1);
        check("post w_ready", 64'(w_ready), 64'd1);
        check("post b_valid", 64'(b_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("post b_valid later", 64'(b_valid), 64'd0);
        rd("post tohost", A_TOHOST, 64'h0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/culsans_tohost_ctrl.md
# culsans_tohost_ctrl

Memory-mapped HTIF tohost/fromhost endpoint on the SoC AXI-Lite peripheral bus of the multicore Culsans system. It is the stage that produces the top-level `exit_o` word consumed by the integration bench's end-of-simulation monitor. Cores write `tohost`; the block decodes exit and console-putchar commands, latches a sticky exit code, pulses console characters out, and acknowledges through `fromhost`.

## Interface
- `AddrWidth`, 64, AXI address width
- `DataWidth`, 64, AXI data width; fixed at 64
- `BaseAddr`, 64'h8000_1000, region base; `tohost` at +0x0, `fromhost` at +0x8
- `RegionMask`, 64'hFFF, offset bits; addresses outside the region never reach this block
- `clk_i`  in  1  clock
- `rst`  in  1  reset rst, asynchronous, active-low
- `aw_valid_i` / `aw_ready_o`  in/out  1  write address handshake
- `aw_addr_i`  in  AddrWidth  write address
- `w_valid_i` / `w_ready_o`  in/out  1  write data handshake
- `w_data_i`  in  64  write data
- `w_strb_i`  in  8  byte strobes
- `b_valid_o` / `b_ready_i`  out/in  1  write response handshake
- `b_resp_o`  out  2  response: 2'b00 OKAY, 2'b10 SLVERR
- `ar_valid_i` / `ar_ready_o`  in/out  1  read address handshake
- `ar_addr_i`  in  AddrWidth  read address
- `r_valid_o` / `r_ready_i`  out/in  1  read data handshake
- `r_data_o`  out  64  read data
- `r_resp_o`  out  2  read response
- `exit_o`  out  32  sticky exit word; bit0 = done, bits 31:1 = code
- `char_valid_o`  out  1  one-cycle console character strobe
- `char_o`  out  8  console character

## Operation
- Registers: `tohost[63:0]` and `fromhost[63:0]`. Both reset to 0. Byte-wise writes under `w_strb_i`.
- Write FSM states:
  - W_IDLE: `aw_ready_o` = `w_ready_o` = 1.
  - W_HAVE_AW: `w_ready_o` = 1 only.
  - W_HAVE_W: `aw_ready_o` = 1 only.
  - W_RESP: both readies 0; `b_valid_o` = 1.
- Write FSM transitions:
  - AW and W accepted in the same W_IDLE cycle → W_RESP.
  - Only one accepted → W_HAVE_AW or W_HAVE_W; the missing one → W_RESP.
  - W_RESP and `b_ready_i` → W_IDLE.
- Commit: the register update occurs on the edge that enters W_RESP.
- Address decode uses offset `aw_addr_i & RegionMask`:
  - 0x0 → `tohost`.
  - 0x8 → `fromhost`.
  - Any other offset → SLVERR, no state change.
- Command decode applies to the merged `tohost` value after a commit:
  - Bit0 = 1 and bits[63:48] = 0 (exit): if `exit_o[0]` = 0, set `exit_o` to `tohost[31:0]`. The first exit wins, and `exit_o` is sticky until reset. `tohost` is then cleared.
  - Bits[63:56] = 1 and bits[55:48] = 1 (putchar): pulse `char_valid_o`, drive `char_o` = data[7:0], clear `tohost`, and set `fromhost` = {8'h01, 8'h01, 47'b0, 1'b1}.
  - Any other non-zero value: retained in `tohost` and readable; no side effect.
- Read FSM:
  - R_IDLE: `ar_ready_o` = 1. On accept, capture the decoded register into `r_data_o` (or 0 with SLVERR) → R_RESP.
  - R_RESP: `r_valid_o` = 1, held until `r_ready_i` → R_IDLE.
- Read and write paths are independent. A read accepted on the same edge as a write commit returns the pre-commit value.
- All `*_ready_o` outputs are forced to 0 while `rst` is low.

## Timing
- Reset values: `b_valid_o`, `r_valid_o`, `b_resp_o`, `r_resp_o`, `r_data_o`, `exit_o`, `char_valid_o`, `char_o` = 0. Readies = 0 during reset and 1 (idle) from the first cycle after release.
- Write response: `b_valid_o` rises one cycle after the later of the AW/W handshakes. `exit_o`, `char_valid_o` and `fromhost` update on that same edge.
- Read latency: `r_valid_o` one cycle after the AR handshake.
- Throughput: at most one write per 2 cycles and one read per 2 cycles.
- Valid/data stability: `b_valid_o`/`r_valid_o` and their data and response stay stable until accepted.
- Reset mid-transaction: reset asserted in any state returns both FSMs to idle and drops any pending response; the transaction is lost. `exit_o` clears.

## Structure
- Shared package `culsans_tohost_pkg`:
  - offsets `TOHOST_OFS`, `FROMHOST_OFS`
  - response codes `RESP_OKAY`, `RESP_SLVERR`
  - device/command constants `DEV_SYS`, `DEV_CONSOLE`, `CMD_PUTCHAR`
  - write and read FSM state enums
- Natural sub-module: `culsans_tohost_decode`, combinational, taking the merged `tohost` value and producing `is_exit`, `is_putchar` and the character.

## Test plan
- Write 64'h1 to +0x0 (AW and W same cycle) → `b_valid_o` next cycle with OKAY; `exit_o` = 32'h1 (success). A following read of +0x0 returns 0.
- Write 64'h55 (code 42) with W one cycle before AW → FSM passes through W_HAVE_W; `exit_o` = 32'h55. A later write of 64'h3 leaves `exit_o` = 32'h55.
- Write 64'h0101_0000_0000_0041 → one-cycle `char_valid_o` with `char_o` = 8'h41. A read of +0x8 returns 64'h0101_0000_0000_0001; `tohost` reads 0.
- Write to +0x10 → `b_resp_o` = 2'b10; no register or `exit_o` change. A read of +0x10 → `r_resp_o` = 2'b10, `r_data_o` = 0.
- Hold `b_ready_i` low 5 cycles → `b_valid_o` held and readies low; the next AW is accepted only after the B handshake. A concurrent read of +0x0 completes meanwhile.
- Assert `rst` while in W_HAVE_AW → after release, readies = 1, `exit_o` = 0, no stray `b_valid_o`.
